eespfal_phase_driver: RTL
=========================

// Module: eespfal_phase_driver
// PURPOSE
// - Digital driver and capture controller for the 4-lane EESPFAL switch macro.
// - Accepts a 4-bit x/k operation over valid/ready and generates the switch's dual-rail inputs,
//   per-lane CLK and Dis, and Dis_Phase.
// - Resynchronises the macro's s/s_bar outputs, checks them for complementary (dual-rail) validity,
//   and returns the result over valid/ready.
// - Sits in the user-project digital area between the wishbone/logic-analyzer control and the analog macro.
// PARAMETERS
// - BIT_SIZE  4  lanes per macro; all vectors below are BIT_SIZE wide unless stated
// - DWELL_W   8  width of the per-phase dwell count
// PORTS
// - wb_clk_i     in   1         system clock; every flop is on its rising edge
// - rst_n        in   1         asynchronous active-low reset
// - dwell_i      in   DWELL_W   cycles per phase; values <3 clamp to 3; sampled at op accept
// - op_valid     in   1         operation request
// - op_ready     out  1         high only in IDLE
// - op_x         in   BIT_SIZE  data operand
// - op_k         in   BIT_SIZE  key operand
// - res_valid    out  1         result available
// - res_ready    in   1         result consumed
// - res_s        out  BIT_SIZE  captured s
// - res_err      out  1         dual-rail violation on any lane
// - err_cnt      out  16        violation count (see CONFIGURATION)
// - clk_o        out  BIT_SIZE  to macro CLK
// - dis_o        out  BIT_SIZE  to macro Dis
// - dis_phase_o  out  1         to macro Dis_Phase
// - x_o          out  BIT_SIZE  to macro x
// - x_bar_o      out  BIT_SIZE  to macro x_bar
// - k_o          out  BIT_SIZE  to macro k
// - k_bar_o      out  BIT_SIZE  to macro k_bar
// - s_i          in   BIT_SIZE  from macro s (asynchronous)
// - s_bar_i      in   BIT_SIZE  from macro s_bar (asynchronous)
// BEHAVIOUR
// - Reset values: op_ready=0, res_valid=0, res_s=0, res_err=0, err_cnt=0, clk_o=0, dis_o=all 1s,
//   dis_phase_o=1, x_o/x_bar_o/k_o/k_bar_o=0, FSM=IDLE.
// - Reset mid-operation drops the operation and any pending result.
// - Input sync: s_i and s_bar_i each pass through a 2-flop synchronizer before any use.
// - FSM states and transitions:
//   - IDLE -> LOAD: on op_valid&op_ready (accept cycle t0). Latch x, k and D=max(dwell_i,3).
//     In IDLE: op_ready=1, clk_o=0, dis_o=1s, dis_phase_o=1, data rails all 0 (null precharge).
//   - LOAD: D cycles. clk_o=0, dis_o=1s, dis_phase_o=1. x_o=x, x_bar_o=~x, k_o=k, k_bar_o=~k.
//   - EVAL: D cycles. clk_o=1s, dis_o=0, dis_phase_o=0, rails held.
//     On the last EVAL cycle, capture res_s = sync(s_i) and res_err = |(sync(s_i) ~^ sync(s_bar_i)).
//   - RECOVER: D cycles. clk_o=0, dis_o=0, dis_phase_o=0, data rails all 0.
//   - RESULT: res_valid=1; res_s and res_err stable; outputs as in IDLE except op_ready=0.
//     Return to IDLE on res_ready.
// - Timing: one dwell counter counts D-1 down to 0 per phase. res_valid rises at t0+1+3D.
//   The first IDLE cycle after a handshake is the earliest possible next accept.
// - Invariant: x_o&x_bar_o==0 and k_o&k_bar_o==0 in every cycle.
// - Invariant: clk_o and dis_o are never both nonzero on the same lane.
// - dwell_i changes during an operation have no effect until the next accept.
// - op_valid while busy is ignored; it is not queued.
// CONFIGURATION
// - EESPFAL_ERRCNT_EN defined: err_cnt increments by 1 on each RESULT entry with res_err=1.
//   It saturates at 16'hFFFF and clears only on reset.
// - EESPFAL_ERRCNT_EN undefined: err_cnt is tied to 0 and the counter logic is not built.
// TESTING
// - 1. dwell=4, x=4'hA, k=4'h5, model s=x^k, s_bar=~s:
//      res_valid at t0+13, res_s=4'hF, res_err=0.
// - 2. dwell=1 (clamped to 3), x=4'h3, k=4'h3, same model:
//      res_valid at t0+10, res_s=4'h0, res_err=0.
// - 3. Stuck model s=s_bar=4'h3, ERRCNT_EN defined, 3 ops:
//      res_err=1 each time, err_cnt=3.
// - 4. res_ready held low 5 cycles after res_valid:
//      res_valid/res_s stay stable, op_ready=0, a concurrent op_valid is not accepted.
// - 5. rst_n pulsed low in the 2nd EVAL cycle:
//      immediately clk_o=0, dis_o=4'hF, dis_phase_o=1; no res_valid afterwards; next op completes normally.
// - 6. Random x/k, dwell 3..20, 200 ops, assertions on:
//      rail exclusivity and clk/dis exclusivity never violated, all results match the model.

Source files
------------

// File: rtl/eespfal_phase_driver_if.sv
// Operation/result handshake bundle between the control side and eespfal_phase_driver.
// The master side issues operations and consumes results; the slave side is the driver.
interface eespfal_phase_driver_if #(
  parameter int BIT_SIZE = 4,
  parameter int DWELL_W  = 8
);
  logic [DWELL_W-1:0]  dwell_i;
  logic                op_valid;
  logic                op_ready;
  logic [BIT_SIZE-1:0] op_x;
  logic [BIT_SIZE-1:0] op_k;
  logic                res_valid;
  logic                res_ready;
  logic [BIT_SIZE-1:0] res_s;
  logic                res_err;
  logic [15:0]         err_cnt;

  modport master (
    output dwell_i, op_valid, op_x, op_k, res_ready,
    input  op_ready, res_valid, res_s, res_err, err_cnt
  );

  modport slave (
    input  dwell_i, op_valid, op_x, op_k, res_ready,
    output op_ready, res_valid, res_s, res_err, err_cnt
  );
endinterface

// File: rtl/eespfal_phase_driver.sv
// Phase sequencer and dual-rail capture controller for the 4-lane EESPFAL switch macro.
// Optional violation counter built only when EESPFAL_ERRCNT_EN is defined.
module eespfal_phase_driver #(
  parameter int BIT_SIZE = 4,
  parameter int DWELL_W  = 8
) (
  input  logic                wb_clk_i,
  input  logic                rst_n,
  eespfal_phase_driver_if.slave op_if,
  output logic [BIT_SIZE-1:0] clk_o,
  output logic [BIT_SIZE-1:0] dis_o,
  output logic                dis_phase_o,
  output logic [BIT_SIZE-1:0] x_o,
  output logic [BIT_SIZE-1:0] x_bar_o,
  output logic [BIT_SIZE-1:0] k_o,
  output logic [BIT_SIZE-1:0] k_bar_o,
  input  logic [BIT_SIZE-1:0] s_i,
  input  logic [BIT_SIZE-1:0] s_bar_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_EVAL    = 3'd2,
    S_RECOVER = 3'd3,
    S_RESULT  = 3'd4
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_MIN = DWELL_W'(3);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_t              state_q, state_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [BIT_SIZE-1:0] x_q, x_d;
  logic [BIT_SIZE-1:0] k_q, k_d;
  logic [BIT_SIZE-1:0] res_s_q, res_s_d;
  logic                res_err_q, res_err_d;
  logic                op_ready_q, op_ready_d;
  logic                res_valid_q, res_valid_d;
  logic [BIT_SIZE-1:0] clk_q, clk_d;
  logic [BIT_SIZE-1:0] dis_q, dis_d;
  logic                dis_phase_q, dis_phase_d;
  logic [BIT_SIZE-1:0] xo_q, xo_d, xbo_q, xbo_d, ko_q, ko_d, kbo_q, kbo_d;
  logic [BIT_SIZE-1:0] s_meta_q, s_sync_q, sb_meta_q, sb_sync_q;
  logic                phase_done;
  logic                accept;

  // Macro outputs are asynchronous to wb_clk_i; two flops per rail before any use.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s_meta_q  <= '0;
      s_sync_q  <= '0;
      sb_meta_q <= '0;
      sb_sync_q <= '0;
    end else begin
      s_meta_q  <= s_i;
      s_sync_q  <= s_meta_q;
      sb_meta_q <= s_bar_i;
      sb_sync_q <= sb_meta_q;
    end
  end

  assign phase_done = (cnt_q == '0);
  assign accept     = op_if.op_valid && op_ready_q;

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    k_d       = k_q;
    res_s_d   = res_s_q;
    res_err_d = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_LOAD;
          dwell_d = (op_if.dwell_i < DWELL_MIN) ? DWELL_MIN : op_if.dwell_i;
          cnt_d   = dwell_d - DWELL_ONE;
          x_d     = op_if.op_x;
          k_d     = op_if.op_k;
        end
      end
      S_LOAD: begin
        if (phase_done) begin
          state_d = S_EVAL;
          cnt_d   = dwell_q - DWELL_ONE;
        end else begin
          cnt_d = cnt_q - DWELL_ONE;
        end
      end
      S_EVAL: begin
        if (phase_done) begin
          state_d   = S_RECOVER;
          cnt_d     = dwell_q - DWELL_ONE;
          res_s_d   = s_sync_q;
          // A lane is invalid when its two rails agree.
          res_err_d = |(s_sync_q ~^ sb_sync_q);
        end else begin
          cnt_d = cnt_q - DWELL_ONE;
        end
      end
      S_RECOVER: begin
        if (phase_done) begin
          state_d = S_RESULT;
        end else begin
          cnt_d = cnt_q - DWELL_ONE;
        end
      end
      S_RESULT: begin
        if (op_if.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Macro-facing and handshake outputs are registered from the next state so they change glitch-free.
  always_comb begin
    op_ready_d  = (state_d == S_IDLE);
    res_valid_d = (state_d == S_RESULT);
    clk_d       = '0;
    dis_d       = '1;
    dis_phase_d = 1'b1;
    xo_d        = '0;
    xbo_d       = '0;
    ko_d        = '0;
    kbo_d       = '0;
    case (state_d)
      S_LOAD: begin
        xo_d  = x_d;
        xbo_d = ~x_d;
        ko_d  = k_d;
        kbo_d = ~k_d;
      end
      S_EVAL: begin
        clk_d       = '1;
        dis_d       = '0;
        dis_phase_d = 1'b0;
        xo_d        = x_d;
        xbo_d       = ~x_d;
        ko_d        = k_d;
        kbo_d       = ~k_d;
      end
      S_RECOVER: begin
        dis_d       = '0;
        dis_phase_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dwell_q     <= DWELL_MIN;
      cnt_q       <= '0;
      x_q         <= '0;
      k_q         <= '0;
      res_s_q     <= '0;
      res_err_q   <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      clk_q       <= '0;
      dis_q       <= '1;
      dis_phase_q <= 1'b1;
      xo_q        <= '0;
      xbo_q       <= '0;
      ko_q        <= '0;
      kbo_q       <= '0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      k_q         <= k_d;
      res_s_q     <= res_s_d;
      res_err_q   <= res_err_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      clk_q       <= clk_d;
      dis_q       <= dis_d;
      dis_phase_q <= dis_phase_d;
      xo_q        <= xo_d;
      xbo_q       <= xbo_d;
      ko_q        <= ko_d;
      kbo_q       <= kbo_d;
    end
  end

`ifdef EESPFAL_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Counts on RESULT entry; res_err_q already holds the capture from the last EVAL cycle.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == S_RECOVER) && phase_done && res_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign op_if.err_cnt = err_cnt_q;
`else
  assign op_if.err_cnt = 16'd0;
`endif

  assign op_if.op_ready  = op_ready_q;
  assign op_if.res_valid = res_valid_q;
  assign op_if.res_s     = res_s_q;
  assign op_if.res_err   = res_err_q;
  assign clk_o           = clk_q;
  assign dis_o           = dis_q;
  assign dis_phase_o     = dis_phase_q;
  assign x_o             = xo_q;
  assign x_bar_o         = xbo_q;
  assign k_o             = ko_q;
  assign k_bar_o         = kbo_q;

endmodule
